// File: rtl/seg7_scan_reader.sv
// Recovers BCD digits from a scanned 4-digit 7-segment bus by applying a stability
// filter to each {an,seg} sample, then assembles the accepted digits into 16-bit frames.
module seg7_scan_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic        digit_valid,
  output logic [1:0]  digit_idx,
  output logic [3:0]  digit_val,
  output logic        frame_valid,
  output logic [15:0] value,
  output logic [3:0]  err
);

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } sample_t;

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  state_t           state;
  sample_t          in_q;
  sample_t          smp;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0][3:0]  pend;
  logic [3:0]       pend_err;
  logic [3:0]       captured;
  logic [3:0]       cap_nxt;
  logic [3:0][3:0]  frame_vals;
  logic [3:0]       frame_errs;
  logic             same, onehot, accept;
  logic [3:0]       dec_val;
  logic             dec_bad;
  logic [1:0]       idx;

  // The state tracks the sample being registered into in_q this edge, so the
  // edge that captures a new pair already counts as the first stable sample.
  assign smp     = '{an: an, seg: seg};
  assign same    = (smp == in_q);
  assign onehot  = $onehot(an);
  assign cnt_nxt = cnt + 1'b1;
  assign accept  = (state == COUNT) && onehot && same &&
                   (cnt_nxt == CNT_W'(STABLE_CYCLES));

  always_comb begin
    dec_bad = 1'b0;
    case (seg)
      7'b1111110: dec_val = 4'd0;
      7'b0110000: dec_val = 4'd1;
      7'b1101101: dec_val = 4'd2;
      7'b1111001: dec_val = 4'd3;
      7'b0110011: dec_val = 4'd4;
      7'b1011011: dec_val = 4'd5;
      7'b1011111: dec_val = 4'd6;
      7'b1110000: dec_val = 4'd7;
      7'b1111111: dec_val = 4'd8;
      7'b1111011: dec_val = 4'd9;
      default: begin
        dec_val = 4'hF;
        dec_bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    case (an)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // The completing digit has not reached its slot yet, so splice it in here.
  always_comb begin
    frame_vals      = pend;
    frame_vals[idx] = dec_val;
    frame_errs      = pend_err;
    frame_errs[idx] = dec_bad;
    cap_nxt         = captured | (4'b0001 << idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_q        <= '0;
      cnt         <= '0;
      pend        <= '0;
      pend_err    <= '0;
      captured    <= '0;
      digit_valid <= 1'b0;
      digit_idx   <= '0;
      digit_val   <= '0;
      frame_valid <= 1'b0;
      value       <= '0;
      err         <= '0;
    end else begin
      in_q        <= smp;
      digit_valid <= 1'b0;
      frame_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (onehot) begin
            state <= COUNT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        COUNT: begin
          if (!onehot) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (!same) begin
            cnt <= CNT_W'(1);
          end else if (accept) begin
            state <= HOLD;
            cnt   <= cnt_nxt;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        HOLD: begin
          if (!onehot) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (!same) begin
            state <= COUNT;
            cnt   <= CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      if (accept) begin
        digit_valid   <= 1'b1;
        digit_idx     <= idx;
        digit_val     <= dec_val;
        pend[idx]     <= dec_val;
        pend_err[idx] <= dec_bad;
        if (cap_nxt == 4'b1111) begin
          frame_valid <= 1'b1;
          value       <= frame_vals;
          err         <= frame_errs;
          captured    <= '0;
        end else begin
          captured <= cap_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: latency, glitch rejection, frames,
// invalid patterns and reset behaviour, with hand-computed expectations.
module tb_seg7_scan_reader;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                         S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                         S7 = 7'b1110000, S8 = 7'b1111111, S9 = 7'b1111011,
                         SB = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        digit_valid;
  logic [1:0]  digit_idx;
  logic [3:0]  digit_val;
  logic        frame_valid;
  logic [15:0] value;
  logic [3:0]  err;

  int vectors = 0;
  int miscompares = 0;

  int       cyc = 0;
  int       dv_n = 0, fv_n = 0, dv_cyc = 0;
  logic [1:0] l_idx = '0, f_idx = '0;
  logic [3:0] l_val = '0;
  logic       f_dv = 1'b0;

  seg7_scan_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
    .digit_valid(digit_valid), .digit_idx(digit_idx), .digit_val(digit_val),
    .frame_valid(frame_valid), .value(value), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (digit_valid) begin
      dv_n   <= dv_n + 1;
      dv_cyc <= cyc;
      l_idx  <= digit_idx;
      l_val  <= digit_val;
    end
    if (frame_valid) begin
      fv_n  <= fv_n + 1;
      f_dv  <= digit_valid;
      f_idx <= digit_idx;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives the pair and waits n falling edges.
  task automatic apply(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    apply(4'b0000, SB, 2);
    rst = 1'b0;
  endtask

  initial begin
    int n0, f0, c0;
    rst = 1'b1;
    an  = '0;
    seg = '0;
    @(negedge clk);

    // Reset with random inputs on the bus
    apply(4'($urandom), 7'($urandom), 1);
    apply(4'($urandom), 7'($urandom), 1);
    check("rst_dv",    32'(digit_valid), 32'd0);
    check("rst_idx",   32'(digit_idx),   32'd0);
    check("rst_val",   32'(digit_val),   32'd0);
    check("rst_fv",    32'(frame_valid), 32'd0);
    check("rst_value", 32'(value),       32'h0);
    check("rst_err",   32'(err),         32'h0);
    rst = 1'b0;
    n0 = dv_n; f0 = fv_n;
    apply(4'b0000, SB, 10);
    check("idle_dv_pulses", 32'(dv_n - n0), 32'd0);
    check("idle_fv_pulses", 32'(fv_n - f0), 32'd0);

    // Accept latency: pulse 4 edges after apply, single pulse while held
    n0 = dv_n; c0 = cyc;
    apply(4'b0001, S2, 24);
    check("lat_pulses", 32'(dv_n - n0),   32'd1);
    check("lat_edges",  32'(dv_cyc - c0), 32'd4);
    check("lat_idx",    32'(l_idx),       32'd0);
    check("lat_val",    32'(l_val),       32'd2);

    // Glitch reject: 3-cycle pattern never accepted
    n0 = dv_n;
    apply(4'b0010, S3, 3);
    apply(4'b0010, S4, 4);
    apply(4'b0000, SB, 3);
    check("glitch_pulses", 32'(dv_n - n0), 32'd1);
    check("glitch_idx",    32'(l_idx),     32'd1);
    check("glitch_val",    32'(l_val),     32'd4);

    // Full frame 1,9,7,0 from a clean capture state
    pulse_rst();
    n0 = dv_n; f0 = fv_n;
    apply(4'b1000, S1, 6);
    apply(4'b0100, S9, 6);
    apply(4'b0010, S7, 6);
    apply(4'b0001, S0, 6);
    apply(4'b0000, SB, 2);
    check("frame_dv_pulses", 32'(dv_n - n0), 32'd4);
    check("frame_pulses",    32'(fv_n - f0), 32'd1);
    check("frame_with_dv",   32'(f_dv),      32'd1);
    check("frame_last_idx",  32'(f_idx),     32'd0);
    check("frame_value",     32'(value),     32'h1970);
    check("frame_err",       32'(err),       32'h0);

    // Two digits selected at once: no acceptance, frame held
    n0 = dv_n;
    apply(4'b0110, S8, 8);
    apply(4'b0000, SB, 2);
    check("multi_an_pulses", 32'(dv_n - n0), 32'd0);
    check("value_held",      32'(value),     32'h1970);

    // Frame with a blank (invalid) digit 2
    f0 = fv_n;
    apply(4'b1000, S5, 6);
    apply(4'b0100, SB, 6);
    apply(4'b0010, S3, 6);
    apply(4'b0001, S8, 6);
    apply(4'b0000, SB, 2);
    check("inv_frame_pulses", 32'(fv_n - f0), 32'd1);
    check("inv_value",        32'(value),     32'h5F38);
    check("inv_err",          32'(err),       32'b0100);

    // Reset mid-frame discards the partial capture
    pulse_rst();
    n0 = dv_n; f0 = fv_n;
    apply(4'b1000, S1, 6);
    apply(4'b0100, S2, 6);
    apply(4'b0010, S3, 6);
    pulse_rst();
    apply(4'b0001, S4, 6);
    apply(4'b0000, SB, 2);
    check("midrst_dv_pulses", 32'(dv_n - n0), 32'd4);
    check("midrst_fv_pulses", 32'(fv_n - f0), 32'd0);
    check("midrst_value",     32'(value),     32'h0);
    check("midrst_err",       32'(err),       32'h0);
    check("midrst_last_val",  32'(l_val),     32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
